// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-drive and result bundle of the ALU issue controller.
// The slave side is the controller; the master side is the upstream
// command source together with the downstream ALU and result consumer.
interface alu_issue_ctrl_if;
  // Command handshake
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_ra;
  logic [2:0] cmd_rb;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;

  // Drive to and result from the registered ALU
  logic [3:0] alu_op;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       alu_ovf;

  // Completion report
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_ovf;
  logic [2:0] res_rd;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  alu_op, alu_in1, alu_in2,
    output alu_out, alu_carry, alu_ovf,
    input  res_valid, res_data, res_carry, res_ovf, res_rd, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output alu_op, alu_in1, alu_in2,
    input  alu_out, alu_carry, alu_ovf,
    output res_valid, res_data, res_carry, res_ovf, res_rd, res_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one register-based command at a time, drives
// a registered ALU for one cycle, captures its result into an 8x8 register
// file and reports completion with a one-cycle pulse.
module alu_issue_ctrl (
  input  logic               clk,
  input  logic               rst,
  alu_issue_ctrl_if.slave    bus,
  input  logic [2:0]         dbg_rsel,
  output logic [7:0]         dbg_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture
  } state_e;

  state_e     state_q, state_d;
  // Low until the first edge after reset release, so cmd_ready stays low in reset.
  logic       live_q;

  logic [7:0] regs_q [8];

  logic [3:0] alu_op_q;
  logic [7:0] alu_in1_q;
  logic [7:0] alu_in2_q;

  logic [2:0] rd_q;
  logic       err_q;

  logic       res_valid_q;
  logic [7:0] res_data_q;
  logic       res_carry_q;
  logic       res_ovf_q;
  logic [2:0] res_rd_q;
  logic       res_err_q;

  logic       cmd_ready;
  logic       accept;
  logic       capture;
  logic       illegal_op;
  logic       wr_en;
  logic [7:0] ra_val;
  logic [7:0] rb_val;

  // Opcodes 14 and 15 are accepted but never reach the ALU.
  assign illegal_op = (bus.cmd_op == 4'b1110) || (bus.cmd_op == 4'b1111);

  // R0 is hardwired to zero on every read port.
  assign ra_val    = (bus.cmd_ra == 3'd0) ? 8'd0 : regs_q[bus.cmd_ra];
  assign rb_val    = (bus.cmd_rb == 3'd0) ? 8'd0 : regs_q[bus.cmd_rb];
  assign dbg_rdata = (dbg_rsel == 3'd0)   ? 8'd0 : regs_q[dbg_rsel];

  assign wr_en = capture && !err_q && (rd_q != 3'd0);

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = live_q;
        accept    = live_q && bus.cmd_valid;
        if (accept) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Operands held so the ALU samples them at the end of this cycle.
        state_d = StCapture;
      end
      StCapture: begin
        capture = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register and post-reset ready enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Latch the command and the ALU drive on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op_q  <= 4'd0;
      alu_in1_q <= 8'd0;
      alu_in2_q <= 8'd0;
      rd_q      <= 3'd0;
      err_q     <= 1'b0;
    end else if (accept) begin
      rd_q  <= bus.cmd_rd;
      err_q <= illegal_op;
      // An illegal opcode leaves the ALU drive untouched.
      if (!illegal_op) begin
        alu_op_q  <= bus.cmd_op;
        alu_in1_q <= ra_val;
        alu_in2_q <= bus.cmd_imm_en ? bus.cmd_imm : rb_val;
      end
    end
  end

  // Register file write-back from the ALU result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else if (wr_en) begin
      regs_q[rd_q] <= bus.alu_out;
    end
  end

  // Completion pulse and held result fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= 8'd0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_rd_q    <= 3'd0;
      res_err_q   <= 1'b0;
    end else begin
      res_valid_q <= capture;
      if (capture) begin
        res_data_q  <= err_q ? 8'd0 : bus.alu_out;
        res_carry_q <= err_q ? 1'b0 : bus.alu_carry;
        res_ovf_q   <= err_q ? 1'b0 : bus.alu_ovf;
        res_rd_q    <= rd_q;
        res_err_q   <= err_q;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.res_err   = res_err_q;

`ifndef SYNTHESIS
  // A completion pulse never lasts two cycles.
  a_pulse_single: assert property (@(posedge clk) disable iff (!rst)
    res_valid_q |=> !res_valid_q);
  // Commands are only taken in the idle state.
  a_accept_idle: assert property (@(posedge clk) disable iff (!rst)
    accept |-> (state_q == StIdle));
  // R0 storage is never written.
  a_r0_zero: assert property (@(posedge clk) disable iff (!rst)
    regs_q[0] == 8'd0);
`endif

endmodule
